// File: rtl/jt12_slotreg_pkg.sv
// Shared types for the jt12 operator-register file: write group codes,
// the 44-bit operator word layout and the buffered-write entry.
package jt12_slotreg_pkg;

  typedef enum logic [2:0] {
    REG_DT1_MUL  = 3'd0,
    REG_TL       = 3'd1,
    REG_KS_AR    = 3'd2,
    REG_AMEN_D1R = 3'd3,
    REG_D2R      = 3'd4,
    REG_D1L_RR   = 3'd5,
    REG_SSG      = 3'd6,
    REG_INVALID  = 3'd7
  } reg_grp_e;

  localparam logic [6:0] TL_RST = 7'd127;

  typedef struct packed {
    logic [6:0] tl;
    logic [2:0] dt1;
    logic [3:0] mul;
    logic [1:0] ks;
    logic [4:0] ar;
    logic       amen;
    logic [4:0] d1r;
    logic [4:0] d2r;
    logic [3:0] d1l;
    logic [3:0] rr;
    logic       ssg_en;
    logic [2:0] ssg_eg;
  } op_word_t;

  localparam int WORD_W = $bits(op_word_t);
  localparam op_word_t WORD_RST = op_word_t'({TL_RST, 37'd0});

  typedef struct packed {
    logic [2:0] grp;
    logic [2:0] ch;
    logic [1:0] op;
    logic [7:0] data;
  } wr_entry_t;

  // Only the fields of the selected group change; everything else is kept.
  function automatic op_word_t apply_write(op_word_t w, logic [2:0] grp, logic [7:0] d);
    op_word_t r;
    r = w;
    case (reg_grp_e'(grp))
      REG_DT1_MUL:  begin r.dt1 = d[6:4]; r.mul = d[3:0]; end
      REG_TL:       r.tl = d[6:0];
      REG_KS_AR:    begin r.ks = d[7:6]; r.ar = d[4:0]; end
      REG_AMEN_D1R: begin r.amen = d[7]; r.d1r = d[4:0]; end
      REG_D2R:      r.d2r = d[4:0];
      REG_D1L_RR:   begin r.d1l = d[7:4]; r.rr = d[3:0]; end
      REG_SSG:      begin r.ssg_en = d[3]; r.ssg_eg = d[2:0]; end
      default:      r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt12_slotreg_if.sv
// CPU-side buffered write port of the operator-register file.
interface jt12_slotreg_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_reg;
  logic [2:0] wr_ch;
  logic [1:0] wr_op;
  logic [7:0] wr_data;
  logic       busy;
  logic       wr_err;

  modport master (
    output wr_valid, wr_reg, wr_ch, wr_op, wr_data,
    input  wr_ready, busy, wr_err
  );

  modport slave (
    input  wr_valid, wr_reg, wr_ch, wr_op, wr_data,
    output wr_ready, busy, wr_err
  );
endinterface

// File: rtl/jt12_slot_fifo.sv
// Small synchronous FIFO holding pending register writes until their slot comes round.
module jt12_slot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/jt12_slotreg.sv
// jt12 operator-register file: slot sequencer, flop-array parameter RAM and
// a write FIFO whose head commits only when the slot counter reaches its target.
module jt12_slotreg
  import jt12_slotreg_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int OPS      = 4,
  parameter int DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  jt12_slotreg_if.slave     bus,
  output logic [2:0]        o_cur_ch,
  output logic [1:0]        o_cur_op,
  output logic              o_zero,
  output logic [6:0]        o_tl,
  output logic [2:0]        o_dt1,
  output logic [3:0]        o_mul,
  output logic [1:0]        o_ks,
  output logic [4:0]        o_ar,
  output logic              o_amen,
  output logic [4:0]        o_d1r,
  output logic [4:0]        o_d2r,
  output logic [3:0]        o_d1l,
  output logic [3:0]        o_rr,
  output logic              o_ssg_en,
  output logic [2:0]        o_ssg_eg
);
  localparam int N  = CHANNELS * OPS;
  localparam int SW = $clog2(N);

  logic [2:0]    r_ch;
  logic [1:0]    r_op;
  logic [SW-1:0] r_slot;
  op_word_t      r_out;
  op_word_t      r_ram [N];
  logic          r_wr_err;

  logic [15:0]   w_fifo_head;
  wr_entry_t     w_head;
  logic          w_full, w_empty;
  logic          w_head_ok, w_hit, w_live, w_commit, w_drop, w_pop, w_push;
  logic          w_last_ch, w_last_op;
  logic [SW-1:0] w_nslot;

  jt12_slot_fifo #(.DEPTH(DEPTH), .WIDTH($bits(wr_entry_t))) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({bus.wr_reg, bus.wr_ch, bus.wr_op, bus.wr_data}),
    .o_head  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head    = wr_entry_t'(w_fifo_head);
  assign w_head_ok = (w_head.grp != REG_INVALID)
                  && ({1'b0, w_head.ch} < 4'(CHANNELS))
                  && ({1'b0, w_head.op} < 3'(OPS));
  assign w_hit     = (w_head.ch == r_ch) && (w_head.op == r_op);
  assign w_live    = i_clk_en && !w_empty;
  assign w_commit  = w_live && w_head_ok && w_hit;
  assign w_drop    = w_live && !w_head_ok;
  assign w_pop     = w_commit || w_drop;

  // Full blocks pushes even when the head pops this cycle.
  assign bus.wr_ready = i_clk_en && !w_full;
  assign w_push       = bus.wr_valid && bus.wr_ready;
  assign bus.busy     = !w_empty;
  assign bus.wr_err   = r_wr_err;

  assign w_last_ch = (r_ch == 3'(CHANNELS - 1));
  assign w_last_op = (r_op == 2'(OPS - 1));
  assign w_nslot   = (r_slot == SW'(N - 1)) ? '0 : r_slot + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ch     <= '0;
      r_op     <= '0;
      r_slot   <= '0;
      r_out    <= WORD_RST;
      r_wr_err <= 1'b0;
      for (int i = 0; i < N; i++) r_ram[i] <= WORD_RST;
    end else begin
      r_wr_err <= w_drop;
      if (i_clk_en) begin
        r_slot <= w_nslot;
        // The next slot always differs from the one being written, so no bypass is needed.
        r_out  <= r_ram[w_nslot];
        if (w_last_ch) begin
          r_ch <= '0;
          r_op <= w_last_op ? 2'd0 : r_op + 1'b1;
        end else begin
          r_ch <= r_ch + 1'b1;
        end
        if (w_commit) r_ram[r_slot] <= apply_write(r_ram[r_slot], w_head.grp, w_head.data);
      end
    end
  end

  assign o_cur_ch = r_ch;
  assign o_cur_op = r_op;
  assign o_zero   = (r_slot == '0);
  assign o_tl     = r_out.tl;
  assign o_dt1    = r_out.dt1;
  assign o_mul    = r_out.mul;
  assign o_ks     = r_out.ks;
  assign o_ar     = r_out.ar;
  assign o_amen   = r_out.amen;
  assign o_d1r    = r_out.d1r;
  assign o_d2r    = r_out.d2r;
  assign o_d1l    = r_out.d1l;
  assign o_rr     = r_out.rr;
  assign o_ssg_en = r_out.ssg_en;
  assign o_ssg_eg = r_out.ssg_eg;
endmodule

// File: tb/tb_jt12_slotreg.sv
// Scoreboard bench for jt12_slotreg: a per-slot field model predicts every cycle's
// outputs into a queue, and a monitor pops and compares them.
module tb_jt12_slotreg;
  localparam int CH    = 6;
  localparam int OPS   = 4;
  localparam int DEPTH = 4;
  localparam int N     = CH * OPS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;

  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic       zero, amen, ssg_en;
  logic [6:0] tl;
  logic [2:0] dt1, ssg_eg;
  logic [3:0] mul, d1l, rr;
  logic [1:0] ks;
  logic [4:0] ar, d1r, d2r;

  jt12_slotreg_if bus ();

  jt12_slotreg #(.CHANNELS(CH), .OPS(OPS), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .bus(bus),
    .o_cur_ch(cur_ch), .o_cur_op(cur_op), .o_zero(zero),
    .o_tl(tl), .o_dt1(dt1), .o_mul(mul), .o_ks(ks), .o_ar(ar), .o_amen(amen),
    .o_d1r(d1r), .o_d2r(d2r), .o_d1l(d1l), .o_rr(rr),
    .o_ssg_en(ssg_en), .o_ssg_eg(ssg_eg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tl, dt1, mul, ks, ar, amen, d1r, d2r, d1l, rr, ssg_en, ssg_eg;
  } fld_t;
  typedef struct { int grp, ch, op, data; } wr_t;
  typedef struct { int ch, op, zero, busy, err, rdy; fld_t f; } exp_t;

  fld_t m_ram [N];
  wr_t  m_q [$];
  exp_t exp_q [$];
  int   m_s = 0;
  fld_t m_out;
  int   errors = 0;
  int   checks = 0;

  function automatic fld_t fld_rst();
    fld_t f;
    f = '{default: 0};
    f.tl = 127;
    return f;
  endfunction

  function automatic fld_t apply(fld_t f0, wr_t w);
    fld_t f;
    int d;
    f = f0;
    d = w.data;
    case (w.grp)
      0: begin f.dt1 = (d >> 4) & 7; f.mul = d & 15; end
      1: f.tl = d & 127;
      2: begin f.ks = (d >> 6) & 3; f.ar = d & 31; end
      3: begin f.amen = (d >> 7) & 1; f.d1r = d & 31; end
      4: f.d2r = d & 31;
      5: begin f.d1l = (d >> 4) & 15; f.rr = d & 15; end
      6: begin f.ssg_en = (d >> 3) & 1; f.ssg_eg = d & 7; end
      default: f = f0;
    endcase
    return f;
  endfunction

  // Reference model, advanced at each rising edge from the inputs driven on the previous falling edge.
  exp_t m_e;
  wr_t  m_h, m_in;
  int   m_err;
  bit   m_acc;
  always @(posedge clk) begin
    m_err = 0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_ram[i] = fld_rst();
      m_q.delete();
      m_s = 0;
      m_out = fld_rst();
    end else if (clk_en) begin
      m_acc = bus.wr_valid && (m_q.size() < DEPTH);
      m_in.grp = bus.wr_reg; m_in.ch = bus.wr_ch; m_in.op = bus.wr_op; m_in.data = bus.wr_data;
      if (m_q.size() > 0) begin
        m_h = m_q[0];
        if (m_h.grp == 7 || m_h.ch >= CH || m_h.op >= OPS) begin
          m_err = 1;
          void'(m_q.pop_front());
        end else if (m_h.op * CH + m_h.ch == m_s) begin
          m_ram[m_s] = apply(m_ram[m_s], m_h);
          void'(m_q.pop_front());
        end
      end
      if (m_acc) m_q.push_back(m_in);
      m_s = (m_s + 1) % N;
      m_out = m_ram[m_s];
    end
    m_e.ch   = m_s % CH;
    m_e.op   = m_s / CH;
    m_e.zero = (m_s == 0);
    m_e.busy = (m_q.size() > 0);
    m_e.err  = m_err;
    m_e.rdy  = clk_en && (m_q.size() < DEPTH);
    m_e.f    = m_out;
    exp_q.push_back(m_e);
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cur_ch", cur_ch, mon_e.ch);
        chk("cur_op", cur_op, mon_e.op);
        chk("zero", zero, mon_e.zero);
        chk("busy", bus.busy, mon_e.busy);
        chk("wr_err", bus.wr_err, mon_e.err);
        chk("wr_ready", bus.wr_ready, mon_e.rdy);
        chk("tl", tl, mon_e.f.tl);
        chk("dt1", dt1, mon_e.f.dt1);
        chk("mul", mul, mon_e.f.mul);
        chk("ks", ks, mon_e.f.ks);
        chk("ar", ar, mon_e.f.ar);
        chk("amen", amen, mon_e.f.amen);
        chk("d1r", d1r, mon_e.f.d1r);
        chk("d2r", d2r, mon_e.f.d2r);
        chk("d1l", d1l, mon_e.f.d1l);
        chk("rr", rr, mon_e.f.rr);
        chk("ssg_en", ssg_en, mon_e.f.ssg_en);
        chk("ssg_eg", ssg_eg, mon_e.f.ssg_eg);
      end
    end
  end

  task automatic drive(bit v, int g, int c, int o, int d, bit en);
    @(negedge clk);
    clk_en       = en;
    bus.wr_valid = v;
    bus.wr_reg   = g[2:0];
    bus.wr_ch    = c[2:0];
    bus.wr_op    = o[1:0];
    bus.wr_data  = d[7:0];
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_reg = '0; bus.wr_ch = '0; bus.wr_op = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(N + 2);
    // Return to slot 0 via reset so the directed writes start at s=0.
    @(negedge clk); rst_n = 1'b0; clk_en = 1'b0; bus.wr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 1, 2, 1, 8'h2A, 1'b1);
    idle(2 * N + 4);
    drive(1'b1, 2, 0, 0, 8'hDF, 1'b1);
    drive(1'b1, 5, 0, 0, 8'h5A, 1'b1);
    idle(2 * N + 4);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, i % 7, CH - 1, OPS - 1, 8'h11 * (i + 1), 1'b1);
    idle(DEPTH * N + 4);
    drive(1'b1, 7, 0, 0, 8'h33, 1'b1);
    drive(1'b1, 1, 6, 0, 8'h44, 1'b1);
    idle(4);
    for (int i = 0; i < 3; i++) drive(1'b1, 1, CH - 1, OPS - 1, 8'h05 + i, 1'b1);
    @(negedge clk); rst_n = 1'b0; bus.wr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle(N + 2);
    for (int i = 0; i < 12; i++) drive(1'b1, 1, i % CH, 0, i, i[0]);
    idle(DEPTH * N);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 4) != 0);
    end
    idle(DEPTH * N + 4);
    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
